// File: rtl/ex_hazard_ctrl_if.sv
// Bundle between the EX-stage pipeline and ex_hazard_ctrl: operand and producer
// tags in, forwarding selects and stall/hold/flush controls out.
interface ex_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic [4:0] ex_reg_dst;
  logic       ex_mem_read;
  logic       ex_valid;
  logic       ex_multicycle;
  logic [4:0] mem_reg_dst;
  logic [4:0] wb_reg_dst;
  logic       mem_reg_write_enable;
  logic       wb_reg_write_enable;
  logic       redirect;

  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic       stall_if;
  logic       stall_id;
  logic       bubble_ex;
  logic       hold_ex;
  logic       flush_if_id;
  logic       flush_id_ex;
  logic       flush_ex;
  logic       mc_done;
  logic       busy;

  modport master (
    output id_rs, id_rt, ex_rs, ex_rt, ex_reg_dst, ex_mem_read, ex_valid,
           ex_multicycle, mem_reg_dst, wb_reg_dst, mem_reg_write_enable,
           wb_reg_write_enable, redirect,
    input  fwd_rs_sel, fwd_rt_sel, stall_if, stall_id, bubble_ex, hold_ex,
           flush_if_id, flush_id_ex, flush_ex, mc_done, busy
  );

  modport slave (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_reg_dst, ex_mem_read, ex_valid,
           ex_multicycle, mem_reg_dst, wb_reg_dst, mem_reg_write_enable,
           wb_reg_write_enable, redirect,
    output fwd_rs_sel, fwd_rt_sel, stall_if, stall_id, bubble_ex, hold_ex,
           flush_if_id, flush_id_ex, flush_ex, mc_done, busy
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: forwarding, load-use/RAW interlock, multi-cycle hold, redirect flush.
// Define EX_HAZARD_FWD_EN to enable operand forwarding; otherwise RAW hazards stall.
module ex_hazard_ctrl #(
  parameter int unsigned MC_CYCLES = 4,
  parameter int unsigned CNT_W     = 4
) (
  input logic             clk,
  input logic             rst,
  ex_hazard_ctrl_if.slave hz
);

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 2);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             mc_start;
  logic             raw_hazard;
  logic [1:0]       fwd_rs;
  logic [1:0]       fwd_rt;
  logic             stall;
  logic             bubble;
  logic             hold;
  logic             flush_pipe;
  logic             flush_op;
  logic             done;

  assign mc_start = hz.ex_valid & hz.ex_multicycle;

`ifdef EX_HAZARD_FWD_EN
  // EX/MEM result is younger than WB, so it takes precedence; r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       mem_we,
                                         input logic [4:0] mem_dst,
                                         input logic       wb_we,
                                         input logic [4:0] wb_dst);
    if (mem_we && (mem_dst != 5'd0) && (mem_dst == src)) return 2'b01;
    if (wb_we && (wb_dst != 5'd0) && (wb_dst == src))    return 2'b10;
    return 2'b00;
  endfunction

  assign fwd_rs = fwd_sel(hz.ex_rs, hz.mem_reg_write_enable, hz.mem_reg_dst,
                          hz.wb_reg_write_enable, hz.wb_reg_dst);
  assign fwd_rt = fwd_sel(hz.ex_rt, hz.mem_reg_write_enable, hz.mem_reg_dst,
                          hz.wb_reg_write_enable, hz.wb_reg_dst);
  assign raw_hazard = hz.ex_mem_read && (hz.ex_reg_dst != 5'd0) &&
                      ((hz.ex_reg_dst == hz.id_rs) || (hz.ex_reg_dst == hz.id_rt));
`else
  logic rs_hit;
  logic rt_hit;
  logic unused_fwd;

  // Without forwarding any in-flight producer in EX or MEM blocks the reader;
  // WB is covered by write-before-read in the regfile.
  assign rs_hit = (hz.id_rs != 5'd0) &&
                  ((hz.ex_valid && (hz.ex_reg_dst == hz.id_rs)) ||
                   (hz.mem_reg_write_enable && (hz.mem_reg_dst == hz.id_rs)));
  assign rt_hit = (hz.id_rt != 5'd0) &&
                  ((hz.ex_valid && (hz.ex_reg_dst == hz.id_rt)) ||
                   (hz.mem_reg_write_enable && (hz.mem_reg_dst == hz.id_rt)));
  assign raw_hazard = rs_hit | rt_hit;
  assign fwd_rs     = 2'b00;
  assign fwd_rt     = 2'b00;
  assign unused_fwd = ^{hz.ex_rs, hz.ex_rt, hz.wb_reg_dst, hz.wb_reg_write_enable,
                        hz.ex_mem_read};
`endif

  // State and occupancy counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and controls; priority redirect > multi-cycle hold > RAW interlock
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    bubble     = 1'b0;
    hold       = 1'b0;
    flush_pipe = 1'b0;
    flush_op   = 1'b0;
    done       = 1'b0;

    if (hz.redirect) begin
      flush_pipe = 1'b1;
      flush_op   = (state_q == MC_BUSY) || mc_start;
      state_d    = RUN;
      cnt_d      = '0;
    end else if (state_q == MC_BUSY) begin
      if (cnt_q != '0) begin
        hold  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        done    = 1'b1;
        state_d = RUN;
      end
    end else if (mc_start) begin
      hold    = 1'b1;
      cnt_d   = CNT_LOAD;
      state_d = MC_BUSY;
    end else if (raw_hazard) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end
  end

  // Outputs are forced quiet while reset is asserted, independent of inputs
  assign hz.fwd_rs_sel  = rst ? fwd_rs : 2'b00;
  assign hz.fwd_rt_sel  = rst ? fwd_rt : 2'b00;
  assign hz.stall_if    = rst & (stall | hold);
  assign hz.stall_id    = rst & (stall | hold);
  assign hz.bubble_ex   = rst & bubble;
  assign hz.hold_ex     = rst & hold;
  assign hz.flush_if_id = rst & flush_pipe;
  assign hz.flush_id_ex = rst & flush_pipe;
  assign hz.flush_ex    = rst & flush_op;
  assign hz.mc_done     = rst & done;
  assign hz.busy        = rst & (state_q == MC_BUSY);

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: vector table, directed multi-cycle/redirect/reset
// sequences, and randomized traffic against a rule-level reference model.
module tb_ex_hazard_ctrl;
  localparam int unsigned MC = 4;
  localparam int unsigned CW = 4;
`ifdef EX_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] rs;
    logic [1:0] rt;
    logic stall_if, stall_id, bubble_ex, hold_ex;
    logic flush_if_id, flush_id_ex, flush_ex, mc_done, busy;
  } out_t;

  typedef struct {
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst;
    logic       ex_rd, ex_v;
    logic [4:0] mem_dst;
    logic       mem_we;
    logic [4:0] wb_dst;
    logic       wb_we;
    logic [1:0] e_rs, e_rt;
    logic       e_stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   occ = 0;
  int   occ_next = 0;
  vec_t tbl[10];

  always #5 clk = ~clk;

  ex_hazard_ctrl_if hif ();
  ex_hazard_ctrl #(.MC_CYCLES(MC), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .hz(hif));

  function automatic out_t actual();
    out_t o;
    o.rs = hif.fwd_rs_sel;        o.rt = hif.fwd_rt_sel;
    o.stall_if = hif.stall_if;    o.stall_id = hif.stall_id;
    o.bubble_ex = hif.bubble_ex;  o.hold_ex = hif.hold_ex;
    o.flush_if_id = hif.flush_if_id; o.flush_id_ex = hif.flush_id_ex;
    o.flush_ex = hif.flush_ex;    o.mc_done = hif.mc_done;
    o.busy = hif.busy;
    return o;
  endfunction

  function automatic out_t ctl(bit stall, bit bubble, bit hold, bit fl, bit flex, bit done, bit bsy);
    out_t o = '0;
    o.stall_if = stall | hold;  o.stall_id = stall | hold;
    o.bubble_ex = bubble;       o.hold_ex = hold;
    o.flush_if_id = fl;         o.flush_id_ex = fl;
    o.flush_ex = flex;          o.mc_done = done;
    o.busy = bsy;
    return o;
  endfunction

  function automatic vec_t mkv(logic [4:0] id_rs, logic [4:0] id_rt, logic [4:0] ex_rs,
                               logic [4:0] ex_rt, logic [4:0] ex_dst, logic ex_rd, logic ex_v,
                               logic [4:0] mem_dst, logic mem_we, logic [4:0] wb_dst,
                               logic wb_we, logic [1:0] e_rs, logic [1:0] e_rt, logic e_stall);
    vec_t v;
    v.id_rs = id_rs; v.id_rt = id_rt; v.ex_rs = ex_rs; v.ex_rt = ex_rt; v.ex_dst = ex_dst;
    v.ex_rd = ex_rd; v.ex_v = ex_v; v.mem_dst = mem_dst; v.mem_we = mem_we;
    v.wb_dst = wb_dst; v.wb_we = wb_we; v.e_rs = e_rs; v.e_rt = e_rt; v.e_stall = e_stall;
    return v;
  endfunction

  // Reference model: occ = cycles the current multi-cycle op has already spent in EX
  function automatic logic [1:0] fwd_ref(logic [4:0] src);
    if (!FWD || src == 5'd0) return 2'b00;
    if (hif.mem_reg_write_enable && hif.mem_reg_dst == src) return 2'b01;
    if (hif.wb_reg_write_enable && hif.wb_reg_dst == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit reads_pending(logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (FWD) return hif.ex_mem_read && hif.ex_reg_dst == r;
    return (hif.ex_valid && hif.ex_reg_dst == r) ||
           (hif.mem_reg_write_enable && hif.mem_reg_dst == r);
  endfunction

  function automatic out_t model(int o_cc);
    out_t o = '0;
    bit start;
    if (!rst) return o;
    start = hif.ex_valid && hif.ex_multicycle;
    o.rs = fwd_ref(hif.ex_rs);
    o.rt = fwd_ref(hif.ex_rt);
    o.busy = (o_cc > 0);
    if (hif.redirect) begin
      o.flush_if_id = 1'b1; o.flush_id_ex = 1'b1;
      o.flush_ex = (o_cc > 0) || start;
    end else if (o_cc > 0) begin
      if (o_cc == int'(MC) - 1) o.mc_done = 1'b1;
      else begin o.hold_ex = 1'b1; o.stall_if = 1'b1; o.stall_id = 1'b1; end
    end else if (start) begin
      o.hold_ex = 1'b1; o.stall_if = 1'b1; o.stall_id = 1'b1;
    end else if (reads_pending(hif.id_rs) || reads_pending(hif.id_rt)) begin
      o.stall_if = 1'b1; o.stall_id = 1'b1; o.bubble_ex = 1'b1;
    end
    return o;
  endfunction

  function automatic int model_next(int o_cc);
    if (!rst || hif.redirect) return 0;
    if (o_cc > 0) return (o_cc == int'(MC) - 1) ? 0 : o_cc + 1;
    if (hif.ex_valid && hif.ex_multicycle) return 1;
    return 0;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t a;
    a = actual();
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, a, exp);
    end
  endtask

  task automatic set_idle();
    hif.id_rs = '0; hif.id_rt = '0; hif.ex_rs = '0; hif.ex_rt = '0; hif.ex_reg_dst = '0;
    hif.ex_mem_read = 1'b0; hif.ex_valid = 1'b0; hif.ex_multicycle = 1'b0;
    hif.mem_reg_dst = '0; hif.wb_reg_dst = '0; hif.mem_reg_write_enable = 1'b0;
    hif.wb_reg_write_enable = 1'b0; hif.redirect = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_mc();
    set_idle();
    hif.ex_valid = 1'b1;
    hif.ex_multicycle = 1'b1;
  endtask

  initial begin
    // Reset asserted with busy-looking inputs: everything must be quiet
    hif.id_rs = 5'd3; hif.id_rt = 5'd7; hif.ex_rs = 5'd3; hif.ex_rt = 5'd7;
    hif.ex_reg_dst = 5'd7; hif.ex_mem_read = 1'b1; hif.ex_valid = 1'b1;
    hif.ex_multicycle = 1'b1; hif.mem_reg_dst = 5'd3; hif.wb_reg_dst = 5'd7;
    hif.mem_reg_write_enable = 1'b1; hif.wb_reg_write_enable = 1'b1; hif.redirect = 1'b1;
    #1 check("reset_quiet", '0);
    next_cycle();
    @(negedge clk) check("reset_held", '0);
    next_cycle();
    set_idle();
    rst = 1'b1;
    @(negedge clk) check("idle_after_reset", '0);

    tbl[0] = mkv(0, 0, 5, 0, 0, 0, 1, 5, 1, 5, 1, FWD ? 2'b01 : 2'b00, 2'b00, 1'b0);
    tbl[1] = mkv(0, 0, 5, 0, 0, 0, 1, 5, 0, 5, 1, FWD ? 2'b10 : 2'b00, 2'b00, 1'b0);
    tbl[2] = mkv(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 2'b00, 2'b00, 1'b0);
    tbl[3] = mkv(0, 0, 5, 9, 0, 0, 1, 9, 1, 5, 1, FWD ? 2'b10 : 2'b00, FWD ? 2'b01 : 2'b00, 1'b0);
    tbl[4] = mkv(2, 7, 0, 0, 7, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1'b1);
    tbl[5] = mkv(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1'b0);
    tbl[6] = mkv(7, 0, 0, 0, 7, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, !FWD);
    tbl[7] = mkv(0, 4, 0, 0, 0, 0, 0, 4, 1, 0, 0, 2'b00, 2'b00, !FWD);
    tbl[8] = mkv(0, 6, 0, 6, 0, 0, 0, 0, 0, 6, 1, 2'b00, FWD ? 2'b10 : 2'b00, 1'b0);
    tbl[9] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      out_t e;
      next_cycle();
      hif.id_rs = tbl[i].id_rs; hif.id_rt = tbl[i].id_rt;
      hif.ex_rs = tbl[i].ex_rs; hif.ex_rt = tbl[i].ex_rt; hif.ex_reg_dst = tbl[i].ex_dst;
      hif.ex_mem_read = tbl[i].ex_rd; hif.ex_valid = tbl[i].ex_v; hif.ex_multicycle = 1'b0;
      hif.mem_reg_dst = tbl[i].mem_dst; hif.mem_reg_write_enable = tbl[i].mem_we;
      hif.wb_reg_dst = tbl[i].wb_dst; hif.wb_reg_write_enable = tbl[i].wb_we;
      hif.redirect = 1'b0;
      e = ctl(tbl[i].e_stall, tbl[i].e_stall, 0, 0, 0, 0, 0);
      e.rs = tbl[i].e_rs;
      e.rt = tbl[i].e_rt;
      @(negedge clk) check($sformatf("vec%0d", i), e);
    end

    // Load to r7 read by ID: EX -> MEM -> WB
    next_cycle(); set_idle();
    hif.ex_valid = 1'b1; hif.ex_mem_read = 1'b1; hif.ex_reg_dst = 5'd7; hif.id_rt = 5'd7;
    @(negedge clk) check("load_use_ex", ctl(1, 1, 0, 0, 0, 0, 0));
    next_cycle();
    hif.ex_valid = 1'b0; hif.ex_mem_read = 1'b0; hif.ex_reg_dst = 5'd0;
    hif.mem_reg_dst = 5'd7; hif.mem_reg_write_enable = 1'b1;
    @(negedge clk) check("load_use_mem", ctl(!FWD, !FWD, 0, 0, 0, 0, 0));
    next_cycle();
    hif.mem_reg_dst = 5'd0; hif.mem_reg_write_enable = 1'b0;
    hif.wb_reg_dst = 5'd7; hif.wb_reg_write_enable = 1'b1;
    @(negedge clk) check("load_use_wb", ctl(0, 0, 0, 0, 0, 0, 0));

    // ALU producer of r3 read by ID
    next_cycle(); set_idle();
    hif.ex_valid = 1'b1; hif.ex_reg_dst = 5'd3; hif.id_rs = 5'd3;
    @(negedge clk) check("alu_raw_ex", ctl(!FWD, !FWD, 0, 0, 0, 0, 0));
    next_cycle();
    hif.ex_valid = 1'b0; hif.ex_reg_dst = 5'd0;
    hif.mem_reg_dst = 5'd3; hif.mem_reg_write_enable = 1'b1;
    @(negedge clk) check("alu_raw_mem", ctl(!FWD, !FWD, 0, 0, 0, 0, 0));
    next_cycle();
    hif.mem_reg_dst = 5'd0; hif.mem_reg_write_enable = 1'b0;
    hif.wb_reg_dst = 5'd3; hif.wb_reg_write_enable = 1'b1;
    @(negedge clk) check("alu_raw_wb", ctl(0, 0, 0, 0, 0, 0, 0));

    // Redirect overrides a load-use stall
    next_cycle(); set_idle();
    hif.ex_mem_read = 1'b1; hif.ex_valid = 1'b1; hif.ex_reg_dst = 5'd7; hif.id_rs = 5'd7;
    hif.redirect = 1'b1;
    @(negedge clk) check("redirect_over_load_use", ctl(0, 0, 0, 1, 0, 0, 0));

    // Two back-to-back multi-cycle ops
    next_cycle(); start_mc();
    for (int op = 0; op < 2; op++) begin
      for (int k = 1; k <= int'(MC); k++) begin
        if (op + k > 1) next_cycle();
        @(negedge clk) check($sformatf("mc_op%0d_c%0d", op, k),
                             ctl(0, 0, k < int'(MC), 0, 0, k == int'(MC), k > 1));
      end
    end
    next_cycle(); set_idle();
    @(negedge clk) check("mc_after_idle", '0);

    // Redirect during the second hold cycle
    next_cycle(); start_mc();
    @(negedge clk) check("redir_hold_c1", ctl(0, 0, 1, 0, 0, 0, 0));
    next_cycle(); hif.redirect = 1'b1;
    @(negedge clk) check("redir_hold_c2", ctl(0, 0, 0, 1, 1, 0, 1));
    next_cycle(); set_idle();
    @(negedge clk) check("redir_hold_after", '0);

    // Redirect coinciding with the mc_done cycle
    next_cycle(); start_mc();
    for (int k = 1; k < int'(MC); k++) begin
      if (k > 1) next_cycle();
      @(negedge clk) check($sformatf("redir_done_c%0d", k), ctl(0, 0, 1, 0, 0, 0, k > 1));
    end
    next_cycle(); hif.redirect = 1'b1;
    @(negedge clk) check("redir_done_last", ctl(0, 0, 0, 1, 1, 0, 1));
    next_cycle(); set_idle();
    @(negedge clk) check("redir_done_after", '0);

    // Asynchronous reset mid-op, then a fresh op takes the full occupancy
    next_cycle(); start_mc();
    next_cycle();
    @(negedge clk) check("rst_mid_busy", ctl(0, 0, 1, 0, 0, 0, 1));
    next_cycle();
    #1 rst = 1'b0;
    #1 check("rst_mid_async", '0);
    next_cycle();
    rst = 1'b1;
    for (int k = 1; k <= int'(MC); k++) begin
      if (k > 1) next_cycle();
      @(negedge clk) check($sformatf("rst_new_op_c%0d", k),
                           ctl(0, 0, k < int'(MC), 0, 0, k == int'(MC), k > 1));
    end
    next_cycle(); set_idle();
    @(negedge clk) check("rst_new_op_after", '0);

    // Randomized traffic against the reference model
    occ_next = 0;
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      occ = occ_next;
      hif.id_rs = 5'($urandom_range(0, 7));      hif.id_rt = 5'($urandom_range(0, 7));
      hif.ex_rs = 5'($urandom_range(0, 7));      hif.ex_rt = 5'($urandom_range(0, 7));
      hif.ex_reg_dst = 5'($urandom_range(0, 7));
      hif.mem_reg_dst = 5'($urandom_range(0, 7)); hif.wb_reg_dst = 5'($urandom_range(0, 7));
      hif.ex_mem_read = ($urandom_range(0, 3) == 0);
      hif.ex_valid = ($urandom_range(0, 3) != 0);
      hif.ex_multicycle = ($urandom_range(0, 5) == 0);
      hif.mem_reg_write_enable = $urandom_range(0, 1) != 0;
      hif.wb_reg_write_enable = $urandom_range(0, 1) != 0;
      hif.redirect = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 79) != 0);
      if (!rst) occ = 0;
      @(negedge clk);
      check($sformatf("rand%0d", n), model(occ));
      occ_next = model_next(occ);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
